// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner and related display/keypad blocks.
// Holds the scan FSM states, the idle row pattern and the column priority encoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    localparam logic [3:0] ROW_IDLE = 4'b1110;
    localparam int         KEY_W    = 4;

    // The lowest-numbered low column wins when several columns read low together.
    function automatic logic [1:0] col_priority(input logic [3:0] col_n);
        logic [1:0] idx;
        idx = 2'd0;
        if (!col_n[0]) begin
            idx = 2'd0;
        end else if (!col_n[1]) begin
            idx = 2'd1;
        end else if (!col_n[2]) begin
            idx = 2'd2;
        end else if (!col_n[3]) begin
            idx = 2'd3;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Bundles the keypad pins, the multiplex strobe and the entry datapath of the scanner.
// The slave side is the scanner; the master side is the board/system around it.
interface keypad_scanner_if #(
    parameter int ENTRY_DIGITS = 6
);
    import keypad_pkg::*;

    logic                      m_f;
    logic                      clr;
    logic [3:0]                col;
    logic [3:0]                row;
    logic [KEY_W-1:0]          key_code;
    logic                      key_valid;
    logic [4*ENTRY_DIGITS-1:0] entry;

    modport master (
        output m_f, clr, col,
        input  row, key_code, key_valid, entry
    );

    modport slave (
        input  m_f, clr, col,
        output row, key_code, key_valid, entry
    );

endinterface

// File: rtl/scan_tick_gen.sv
// Turns the asynchronous multiplex square wave into a one-clk strobe per rising edge.
// Shared with the display driver so both sides step on the same multiplex rhythm.
module scan_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic m_f,
    output logic tick
);

    logic m_f_meta_r;
    logic m_f_sync_r;
    logic m_f_sync_d_r;

    // Two-flop synchronizer followed by one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_f_meta_r   <= 1'b0;
            m_f_sync_r   <= 1'b0;
            m_f_sync_d_r <= 1'b0;
        end else begin
            m_f_meta_r   <= m_f;
            m_f_sync_r   <= m_f_meta_r;
            m_f_sync_d_r <= m_f_sync_r;
        end
    end

    assign tick = m_f_sync_r & ~m_f_sync_d_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner with tick-based debounce; accepted key codes are shifted
// into a hex entry register that feeds the multiplexed display driver directly.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int ENTRY_DIGITS   = 6
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.slave   kp
);

    localparam int         ENTRY_W   = 4 * ENTRY_DIGITS;
    localparam logic [7:0] DEB_LIMIT = 8'(DEBOUNCE_TICKS);

    logic              tick_s;
    logic [3:0]        col_meta_r;
    logic [3:0]        col_sync_r;

    scan_state_t       state_r;
    logic [1:0]        row_idx_r;
    logic [1:0]        col_idx_r;
    logic [7:0]        cnt_r;
    logic [3:0]        row_r;
    logic [KEY_W-1:0]  key_code_r;
    logic              key_valid_r;
    logic [ENTRY_W-1:0] entry_r;

    logic              all_up_s;
    logic              held_s;
    logic [1:0]        prio_s;
    logic [7:0]        cnt_inc_s;
    logic              accept_s;
    logic [KEY_W-1:0]  accept_code_s;

    scan_tick_gen u_tick (
        .clk  (clk),
        .rst  (rst),
        .m_f  (kp.m_f),
        .tick (tick_s)
    );

    // Column synchronizer; idles high like the pulled-up keypad lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta_r <= 4'hF;
            col_sync_r <= 4'hF;
        end else begin
            col_meta_r <= kp.col;
            col_sync_r <= col_meta_r;
        end
    end

    // Column decode and accept detection for the current tick.
    always_comb begin
        all_up_s      = (col_sync_r == 4'hF);
        prio_s        = col_priority(col_sync_r);
        held_s        = ~col_sync_r[col_idx_r];
        cnt_inc_s     = cnt_r + 8'd1;
        accept_s      = 1'b0;
        accept_code_s = {row_idx_r, col_idx_r};
        if (tick_s && (state_r == SCAN) && !all_up_s && (DEB_LIMIT == 8'd1)) begin
            accept_s      = 1'b1;
            accept_code_s = {row_idx_r, prio_s};
        end else if (tick_s && (state_r == DEBOUNCE) && held_s && (cnt_inc_s == DEB_LIMIT)) begin
            accept_s      = 1'b1;
        end else begin
            accept_s      = 1'b0;
        end
    end

    // Scan/debounce FSM together with its registered row, key and entry outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= SCAN;
            row_idx_r   <= 2'd0;
            col_idx_r   <= 2'd0;
            cnt_r       <= 8'd0;
            row_r       <= ROW_IDLE;
            key_code_r  <= '0;
            key_valid_r <= 1'b0;
            entry_r     <= '0;
        end else begin
            key_valid_r <= accept_s;
            if (accept_s) begin
                key_code_r <= accept_code_s;
            end else begin
                key_code_r <= key_code_r;
            end
            // clr has priority: a key accepted in the same cycle is dropped from entry.
            if (kp.clr) begin
                entry_r <= '0;
            end else if (accept_s) begin
                entry_r <= {entry_r[ENTRY_W-KEY_W-1:0], accept_code_s};
            end else begin
                entry_r <= entry_r;
            end

            if (tick_s) begin
                case (state_r)
                    SCAN: begin
                        if (all_up_s) begin
                            row_idx_r <= row_idx_r + 2'd1;
                            row_r     <= {row_r[2:0], row_r[3]};
                        end else begin
                            col_idx_r <= prio_s;
                            cnt_r     <= 8'd1;
                            state_r   <= accept_s ? PRESSED : DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (held_s) begin
                            cnt_r   <= cnt_inc_s;
                            state_r <= accept_s ? PRESSED : DEBOUNCE;
                        end else begin
                            state_r   <= SCAN;
                            row_idx_r <= row_idx_r + 2'd1;
                            row_r     <= {row_r[2:0], row_r[3]};
                        end
                    end
                    PRESSED: begin
                        if (all_up_s && (DEB_LIMIT == 8'd1)) begin
                            state_r   <= SCAN;
                            row_idx_r <= row_idx_r + 2'd1;
                            row_r     <= {row_r[2:0], row_r[3]};
                        end else if (all_up_s) begin
                            cnt_r   <= 8'd1;
                            state_r <= RELEASE;
                        end else begin
                            state_r <= PRESSED;
                        end
                    end
                    RELEASE: begin
                        if (all_up_s && (cnt_inc_s == DEB_LIMIT)) begin
                            state_r   <= SCAN;
                            row_idx_r <= row_idx_r + 2'd1;
                            row_r     <= {row_r[2:0], row_r[3]};
                        end else if (all_up_s) begin
                            cnt_r <= cnt_inc_s;
                        end else begin
                            state_r <= PRESSED;
                        end
                    end
                    default: begin
                        state_r   <= SCAN;
                        row_idx_r <= 2'd0;
                        row_r     <= ROW_IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign kp.row       = row_r;
    assign kp.key_code  = key_code_r;
    assign kp.key_valid = key_valid_r;
    assign kp.entry     = entry_r;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 hex keypad matrix and debounces it.
- Each accepted key produces a 4-bit code, which is shifted into a 24-bit entry register.
- Input-side counterpart of the multiplexed 6-digit display driver: same slow m_f multiplex strobe, and its entry output feeds the driver's hex input directly.
- Sits between the board keypad pins and the processor/display datapath.

Parameters:
- DEBOUNCE_TICKS, 4: consecutive m_f ticks a press or release must be stable before it is accepted; legal range 1..255.
- ENTRY_DIGITS, 6: number of hex digits held in entry; entry width is 4*ENTRY_DIGITS.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- m_f  input  1  multiplex-frequency square wave, asynchronous to the block's logic; each rising edge is one scan tick.
- clr  input  1  synchronous entry clear; zeroes entry only.
- col  input  4  keypad column inputs; active-low with pull-ups; asynchronous.
- row  output  4  keypad row drive; active-low one-hot.
- key_code  output  4  code of the last accepted key: {row_idx[1:0], col_idx[1:0]}.
- key_valid  output  1  one-clk pulse per accepted key.
- entry  output  24  shift register of accepted codes; newest code in [3:0].

Behaviour:
- Tick generation: m_f and col each pass through 2-flop synchronizers. tick = m_f_s & ~m_f_s_d, a 1-clk strobe. All state transitions below occur only in tick cycles.
- Reset values: row=4'b1110 (row_idx 0); key_code=0; key_valid=0; entry=0; state=SCAN; debounce counter=0; synchronizer flops=all-ones/0.
- SCAN:
  - On tick with col_s==4'hF: rotate row left (1110->1101->1011->0111->1110); row_idx increments mod 4.
  - On tick with col_s!=4'hF: latch row_idx, and col_idx = lowest-index low column bit. Row is held, cnt=1, go to DEBOUNCE.
  - If DEBOUNCE_TICKS==1, go directly to accept.
- DEBOUNCE:
  - On tick, if col_s[col_idx]==0: cnt++.
  - When cnt reaches DEBOUNCE_TICKS: accept (see below) and go to PRESSED.
  - If col_s[col_idx]==1 on any tick: return to SCAN, rotate row, no output.
- Accept:
  - In the clk cycle after the accepting tick: key_valid=1 for exactly one cycle.
  - key_code={row_idx,col_idx} in the same cycle.
  - entry <= {entry[19:0], key_code} in the same cycle; the oldest digit is discarded.
  - key_code holds its value until the next accept.
- PRESSED:
  - Row stays held.
  - On tick with col_s==4'hF: cnt=1, go to RELEASE.
  - Any other column pattern is ignored; no second key while one is held.
- RELEASE:
  - On tick with col_s==4'hF: cnt++. At DEBOUNCE_TICKS, go to SCAN and rotate row.
  - On tick with any low column: back to PRESSED; no new key_valid.
- clr:
  - Zeroes entry on the next edge, without affecting the FSM.
  - If clr and accept coincide, clr wins: entry=0 and the key is dropped from entry. key_valid and key_code still fire.
- rst mid-operation: returns everything to reset values on the next edge. A still-held key is re-detected from SCAN and yields exactly one new pulse after a full debounce.
- Latency: the key must be low in a scan sample and in DEBOUNCE_TICKS total consecutive tick samples. key_valid follows the final tick strobe by 1 clk.
- Rows are not driven undefined at any time; exactly one row is low at all times.

Decomposition:
- Shared package keypad_pkg:
  - state enum: SCAN, DEBOUNCE, PRESSED, RELEASE.
  - ROW_IDLE=4'b1110.
  - KEY_W=4.
  - col-priority function returning the lowest low bit index.
- Sub-module scan_tick_gen: 2-flop sync of m_f plus rising-edge detect, output tick. Reused by the display driver for its own multiplex strobe.

Test Plan:
Bench: clk period 20 ns, m_f half-period 100 ns (tick every 10 clk), DEBOUNCE_TICKS=4.
1. rst high 2 clk, col=F -> row=1110, entry=0, key_valid=0. Afterwards row steps 1101, 1011, 0111, 1110 on successive ticks.
2. Model key row2/col1 (col=1101 whenever row==1011), held 20 ticks -> exactly one key_valid, key_code=4'h9, entry=24'h000009. Row frozen at 1011 until released 4 ticks.
3. Bounce: key row1/col0 low for 2 ticks then released -> no key_valid, entry unchanged, scanning resumes.
4. Press/release codes F,E,D,C,B,A in order (F=row3/col3) -> six pulses, entry=24'hFEDCBA; one more key 0 -> entry=24'hEDCBA0.
5. Row0 with col=1010 (col0 and col2 low) -> key_code=4'h0. Release glitch (one low tick during RELEASE) -> no extra pulse.
6. rst asserted during DEBOUNCE with key held -> reset values, then one fresh pulse after 4 ticks. clr coincident with accept -> entry=0, key_valid=1.
